// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - LED bus codes, phase/error enums and the LED code decoder
// Shared by the LED sequence monitor and its dwell timer.
package led_pkg;

  // Active-low LED codes as driven by the light controller.
  localparam logic [2:0] LED_RED   = 3'b110;
  localparam logic [2:0] LED_BLUE  = 3'b011;
  localparam logic [2:0] LED_GREEN = 3'b101;

  typedef enum logic [1:0] {
    PH_RED     = 2'd0,
    PH_BLUE    = 2'd1,
    PH_GREEN   = 2'd2,
    PH_INVALID = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SEQ  = 2'd1,
    ERR_TIME = 2'd2,
    ERR_CODE = 2'd3
  } err_t;

  // Any code other than the three legal ones (including all-off or
  // several colours lit at once) decodes to PH_INVALID.
  function automatic phase_t decode_led(input logic [2:0] code);
    phase_t ph;
    case (code)
      LED_RED:   ph = PH_RED;
      LED_BLUE:  ph = PH_BLUE;
      LED_GREEN: ph = PH_GREEN;
      default:   ph = PH_INVALID;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/led_sequence_monitor_dwell_timer.sv
// rtl/led_sequence_monitor_dwell_timer.sv - saturating dwell counter with window and limit compares
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   change      a phase change is seen this cycle; the counter reloads to 1
//   dwell       cycles spent in the current phase (saturates at all-ones)
//   in_window   dwell within [PHASE_CYCLES-TOL, PHASE_CYCLES+TOL]
//   over_limit  dwell at or beyond PHASE_CYCLES+TOL+1
module dwell_timer #(
  parameter int PHASE_CYCLES = 30_000_000,
  parameter int TOL          = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change,
  output logic [CNT_W-1:0] dwell,
  output logic             in_window,
  output logic             over_limit
);

  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(PHASE_CYCLES - TOL);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(PHASE_CYCLES + TOL);
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(PHASE_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0] SAT    = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // On a change the value seen this cycle is the length of the phase just
  // left; the new phase has then been present for one cycle, hence load 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (change) begin
      dwell <= ONE;
    end else if (dwell != SAT) begin
      dwell <= dwell + ONE;
    end
  end

  assign in_window  = (dwell >= WIN_LO) && (dwell <= WIN_HI);
  assign over_limit = (dwell >= LIMIT);

endmodule

// File: rtl/led_sequence_monitor.sv
// rtl/led_sequence_monitor.sv - checks LED bus phase order and dwell time, reports errors
// Ports:
//   clk         system clock
//   button_0    asynchronous active-low reset
//   led         active-low LED code under test
//   phase       decoded phase of the registered LED code (1-cycle latency)
//   err_pulse   one-cycle pulse per detected error
//   err_code    cause of the latest error, held until the next one
//   err_sticky  set on the first error, cleared only by reset
//   err_count   number of errors, saturating at 255
module led_sequence_monitor
  import led_pkg::*;
#(
  parameter int PHASE_CYCLES = 30_000_000,
  parameter int TOL          = 16,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       button_0,
  input  logic [2:0] led,
  output logic [1:0] phase,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic       err_sticky,
  output logic [7:0] err_count
);

  logic [2:0]       led_q;
  phase_t           cur_phase;
  phase_t           prev_phase, prev_phase_next;
  logic             came_from_green, came_from_green_next;
  logic             timeout_armed, timeout_armed_next;
  logic [1:0]       boot_q;
  err_t             err_q, err_next;
  logic             change;
  logic             in_window, over_limit;
  logic [CNT_W-1:0] dwell;
  logic             stuck_fire, timed_change;

  dwell_timer #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .TOL         (TOL),
    .CNT_W       (CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (button_0),
    .change    (change),
    .dwell     (dwell),
    .in_window (in_window),
    .over_limit(over_limit)
  );

  assign cur_phase = decode_led(led_q);
  assign phase     = cur_phase;
  assign change    = (cur_phase != prev_phase);
  assign err_code  = err_q;

  always_ff @(posedge clk or negedge button_0) begin
    if (!button_0) begin
      led_q           <= LED_RED;
      prev_phase      <= PH_RED;
      came_from_green <= 1'b0;
      timeout_armed   <= 1'b1;
      boot_q          <= 2'b00;
      err_pulse       <= 1'b0;
      err_q           <= ERR_NONE;
      err_sticky      <= 1'b0;
      err_count       <= 8'd0;
    end else begin
      led_q           <= led;
      prev_phase      <= prev_phase_next;
      came_from_green <= came_from_green_next;
      timeout_armed   <= timeout_armed_next;
      boot_q          <= {boot_q[0], 1'b1};
      err_pulse       <= (err_next != ERR_NONE);
      if (err_next != ERR_NONE) begin
        err_q      <= err_next;
        err_sticky <= 1'b1;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

  always_comb begin
    prev_phase_next      = prev_phase;
    came_from_green_next = came_from_green;
    timeout_armed_next   = timeout_armed;
    err_next             = ERR_NONE;

    // Stuck check looks at the phase we have been sitting in, so it can
    // coincide with a change on the same cycle; priority sorts that out.
    stuck_fire = ((prev_phase == PH_BLUE) || (prev_phase == PH_GREEN)) &&
                 timeout_armed && over_limit;

    // Only full-length phases of a running cycle are timed; a RED reached
    // any other way than from GREEN is a stop and may last arbitrarily.
    timed_change = change &&
                   (((prev_phase == PH_BLUE) && (cur_phase == PH_GREEN)) ||
                    ((prev_phase == PH_RED) && (cur_phase == PH_BLUE) && came_from_green));

    if (change && (cur_phase == PH_INVALID)) begin
      err_next = ERR_CODE;
    end else if (change && (prev_phase == PH_GREEN) && (cur_phase == PH_BLUE)) begin
      err_next = ERR_SEQ;
    end else if ((timed_change && !in_window) || stuck_fire) begin
      err_next = ERR_TIME;
    end

    // led_q holds the reset default until the first real sample lands, and
    // that sample is compared against a history that never existed.
    if (!boot_q[1]) begin
      err_next = ERR_NONE;
    end

    if (change) begin
      prev_phase_next      = cur_phase;
      came_from_green_next = (cur_phase == PH_RED) && (prev_phase == PH_GREEN);
      timeout_armed_next   = 1'b1;
    end else if (stuck_fire) begin
      timeout_armed_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_led_sequence_monitor.sv
// tb/tb_led_sequence_monitor.sv - directed scoreboard bench for led_sequence_monitor
module tb_led_sequence_monitor;
  import led_pkg::*;

  localparam int PC  = 100;
  localparam int TOL = 2;
  localparam logic [2:0] LED_INV = 3'b111;

  logic       clk = 1'b0;
  logic       button_0;
  logic [2:0] led;
  logic [1:0] phase;
  logic       err_pulse;
  logic [1:0] err_code;
  logic       err_sticky;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_cnt = 0;
  int popped;

  led_sequence_monitor #(.PHASE_CYCLES(PC), .TOL(TOL), .CNT_W(16)) dut (
    .clk       (clk),
    .button_0  (button_0),
    .led       (led),
    .phase     (phase),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_sticky(err_sticky),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves led at code for n rising edges.
  task automatic step(input logic [2:0] code, input int n);
    led = code;
    repeat (n) @(negedge clk);
  endtask

  // Every error pulse must match the oldest expected error in the queue.
  always @(negedge clk) begin
    if (button_0 === 1'b1 && err_pulse === 1'b1) begin
      chk("pulse_was_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        chk("err_code_at_pulse", err_code, popped);
        chk("err_count_at_pulse", err_count, exp_cnt);
        chk("err_sticky_at_pulse", err_sticky, 1);
      end
    end
  end

  initial begin
    button_0 = 1'b0;
    led      = LED_RED;
    repeat (2) @(negedge clk);
    chk("reset_phase", phase, PH_RED);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_err_code", err_code, ERR_NONE);
    chk("reset_err_sticky", err_sticky, 0);
    chk("reset_err_count", err_count, 0);
    button_0 = 1'b1;

    // Legal running cycle, phase lags led by one cycle.
    step(LED_RED, 50);
    led = LED_GREEN;
    #1 chk("phase_lag_old", phase, PH_RED);
    @(negedge clk);
    chk("phase_lag_new", phase, PH_GREEN);
    repeat (99) @(negedge clk);
    step(LED_RED, 100);
    step(LED_BLUE, 100);
    step(LED_GREEN, 100);
    step(LED_RED, 100);
    chk("legal_cycle_count", err_count, 0);
    chk("legal_cycle_sticky", err_sticky, 0);
    chk("legal_cycle_code", err_code, ERR_NONE);

    // Short BLUE: TIME error two edges after the led change.
    step(LED_BLUE, 97);
    led = LED_GREEN;
    exp_q.push_back(ERR_TIME);
    @(negedge clk);
    chk("time_latency_early", err_pulse, 0);
    @(negedge clk);
    chk("time_latency_pulse", err_pulse, 1);
    repeat (98) @(negedge clk);
    step(LED_RED, 10);

    // Stuck GREEN: a single TIME pulse.
    exp_q.push_back(ERR_TIME);
    step(LED_GREEN, 200);
    chk("stuck_count", err_count, 2);
    chk("stuck_code", err_code, ERR_TIME);
    step(LED_RED, 5);

    // GREEN -> BLUE is SEQ, then an invalid code raises CODE once.
    step(LED_GREEN, 100);
    exp_q.push_back(ERR_SEQ);
    step(LED_BLUE, 10);
    chk("seq_code", err_code, ERR_SEQ);
    exp_q.push_back(ERR_CODE);
    step(LED_INV, 5);
    chk("invalid_phase", phase, PH_INVALID);
    chk("invalid_code", err_code, ERR_CODE);
    step(LED_RED, 5);
    chk("invalid_count", err_count, 4);

    // Invalid code arriving exactly at the stuck limit: CODE only.
    step(LED_GREEN, PC + TOL + 1);
    exp_q.push_back(ERR_CODE);
    step(LED_INV, 3);
    step(LED_RED, 5);
    chk("coincide_code", err_code, ERR_CODE);
    chk("coincide_count", err_count, 5);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      step(LED_GREEN, 1);
      exp_q.push_back(ERR_SEQ);
      step(LED_BLUE, 1);
      step(LED_RED, 1);
    end
    step(LED_RED, 5);
    chk("sat_count", err_count, 255);
    chk("sat_queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a phase.
    step(LED_GREEN, 20);
    @(posedge clk);
    #3 button_0 = 1'b0;
    #1;
    chk("async_phase", phase, PH_RED);
    chk("async_err_code", err_code, ERR_NONE);
    chk("async_err_sticky", err_sticky, 0);
    chk("async_err_count", err_count, 0);
    chk("async_err_pulse", err_pulse, 0);
    exp_cnt = 0;
    led = LED_INV;
    @(negedge clk);
    button_0 = 1'b1;

    // First sample after reset is invalid: no error reported.
    step(LED_INV, 5);
    chk("post_reset_phase", phase, PH_INVALID);
    step(LED_RED, 5);
    chk("post_reset_count", err_count, 0);
    chk("post_reset_sticky", err_sticky, 0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
